// File: rtl/param_sp_ram.sv
// param_sp_ram: single-port RAM with a pattern init sweep, 1- or 2-cycle read latency
// and read-first / write-first output on writes.
module param_sp_ram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int INIT_TYPE = 0,
    parameter int RD_LAT    = 1,
    parameter int WR_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              init_start,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);
    typedef enum logic {INIT, READY} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] rd_data, s_data, p_data;
    logic              acc, s_valid, p_valid;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] i);
        logic [63:0] ix, p;
        ix = 64'(i);
        p = (INIT_TYPE == 1 && ix < 64'd8)  ? 64'h11 * (ix + 64'd1) :
            (INIT_TYPE == 2 && ix < 64'd16) ? ix : 64'd0;
        return p[DATA_W-1:0];
    endfunction

    assign ready   = (state == READY);
    assign acc     = req & ready;
    assign rd_data = (WR_MODE == 1 && we) ? din : ram[addr];
    // The stage register only sits in the output path for the two-cycle latency.
    assign p_valid = (RD_LAT == 2) ? s_valid : acc;
    assign p_data  = (RD_LAT == 2) ? s_data : rd_data;

    always_comb begin
        cnt_n   = (state == INIT) ? cnt + 1'b1 : '0;
        state_n = (state == INIT) ? ((&cnt) ? READY : INIT) : (init_start ? INIT : READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Contents are never reset; the sweep rewrites every word after reset.
    always_ff @(posedge clk) begin
        if (state == INIT)
            ram[cnt] <= pattern(cnt);
        else if (acc && we)
            ram[addr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid    <= 1'b0;
            s_data     <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            s_valid    <= acc;
            if (acc)
                s_data <= rd_data;
            dout_valid <= p_valid;
            if (p_valid)
                dout <= p_data;
        end
    end
endmodule

// File: tb/tb_param_sp_ram.sv
// tb_param_sp_ram: directed checks of param_sp_ram across three parameter sets.
module tb_param_sp_ram;
    logic        clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    logic        req = 1'b0, we = 1'b0, init_start = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] din = '0;
    logic        req2 = 1'b0, we2 = 1'b0;
    logic [2:0]  addr2 = '0;
    logic [3:0]  din2 = '0;
    logic        ready0, ready1, ready2, dv0, dv1, dv2;
    logic [15:0] dout0;
    logic [7:0]  dout1;
    logic [3:0]  dout2;
    int          checks = 0, fails = 0, n, dvc;
    logic [15:0] exp0 [9] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055,
                              16'h0066, 16'h0077, 16'h0088, 16'h0000};
    logic [3:0]  exp2 [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [7:0]  lat_d [5] = '{8'h08, 8'h05, 8'h06, 8'h07, 8'h07};
    logic        lat_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    param_sp_ram #(.DATA_W(16), .ADDR_W(8), .INIT_TYPE(1), .RD_LAT(1), .WR_MODE(0)) u0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
        .init_start(init_start), .ready(ready0), .dout(dout0), .dout_valid(dv0));
    param_sp_ram #(.DATA_W(8), .ADDR_W(8), .INIT_TYPE(2), .RD_LAT(2), .WR_MODE(1)) u1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din[7:0]),
        .init_start(init_start), .ready(ready1), .dout(dout1), .dout_valid(dv1));
    param_sp_ram #(.DATA_W(4), .ADDR_W(3), .INIT_TYPE(1), .RD_LAT(1), .WR_MODE(1)) u2 (
        .clk(clk), .rst(rst2), .req(req2), .we(we2), .addr(addr2), .din(din2),
        .init_start(1'b0), .ready(ready2), .dout(dout2), .dout_valid(dv2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick;
        check("rst_ready", ready0, 0);
        check("rst_dout", dout0, 0);
        check("rst_dv", dv1, 0);
        // Writes issued throughout the power-up sweep must be ignored.
        req = 1; we = 1; addr = 0; din = 16'hFFFF; rst = 0;
        n = 0; dvc = 0;
        while (!ready0 && n < 300) begin
            tick; n++;
            dvc += int'(dv0) + int'(dv1);
        end
        req = 0; we = 0;
        check("init_len", n, 256);
        check("init_ready1", ready1, 1);
        check("init_no_dv", dvc, 0);
        for (int i = 0; i < 9; i++) begin
            req = 1; addr = 8'(i);
            tick;
            check("rd_dv", dv0, 1);
            check("rd_data", dout0, exp0[i]);
        end
        req = 0;
        tick;
        check("idle_dv", dv0, 0);
        for (int i = 0; i < 5; i++) begin
            req = (i < 3); addr = 8'(5 + i);
            tick;
            check("lat_dv", dv1, lat_v[i]);
            check("lat_data", dout1, lat_d[i]);
        end
        req = 1; we = 1; addr = 3; din = 16'h00A5;
        tick;
        check("wr0_dv", dv0, 1);
        check("wr0_old", dout0, 16'h0044);
        we = 0;
        tick;
        check("rd0_new", dout0, 16'h00A5);
        check("wr1_dv", dv1, 1);
        check("wr1_din", dout1, 8'hA5);
        req = 0;
        tick;
        check("rd1_new", dout1, 8'hA5);
        check("rd0_idle", dv0, 0);
        req = 1; we = 1; addr = 0; din = 16'h00FF;
        tick;
        check("pre_wr_old", dout0, 16'h0011);
        we = 0; init_start = 1;
        tick;
        check("reinit_rd", dout0, 16'h00FF);
        check("reinit_dv", dv0, 1);
        check("reinit_ready", ready0, 0);
        req = 0; init_start = 0;
        n = 0; dvc = 0;
        while (!ready0 && n < 300) begin
            tick; n++;
            if (n == 1) begin
                check("inflight_dv", dv1, 1);
                check("inflight_data", dout1, 8'hFF);
                dvc += int'(dv0);
            end else
                dvc += int'(dv0) + int'(dv1);
            init_start = (n >= 10 && n < 20);
            req = 1; we = 1; addr = 0; din = 16'h1234;
        end
        req = 0; we = 0; init_start = 0;
        check("reinit_len", n, 256);
        check("reinit_no_dv", dvc, 0);
        req = 1; addr = 0;
        tick;
        check("reinit_rd0", dout0, 16'h0011);
        addr = 5;
        tick;
        check("pre_rst_rd", dout0, 16'h0066);
        req = 0; rst = 1;
        #1;
        check("async_ready", ready0, 0);
        check("async_dv", dv0, 0);
        check("async_dout", dout0, 0);
        tick;
        check("rst_drop", dv1, 0);
        rst = 0;
        repeat (100) tick;
        rst = 1;
        tick;
        rst = 0;
        n = 0; dvc = 0;
        while (!ready0 && n < 300) begin
            tick; n++;
            dvc += int'(dv0) + int'(dv1);
        end
        check("rst_mid_len", n, 256);
        check("rst_mid_no_dv", dvc, 0);
        rst2 = 0;
        n = 0;
        while (!ready2 && n < 50) begin
            tick; n++;
        end
        check("u2_len", n, 8);
        for (int i = 0; i < 8; i++) begin
            req2 = 1; we2 = 0; addr2 = 3'(i);
            tick;
            check("u2_rd", dout2, exp2[i]);
        end
        we2 = 1; addr2 = 2; din2 = 4'hC;
        tick;
        check("u2_wr_din", dout2, 4'hC);
        we2 = 0;
        tick;
        check("u2_rd_new", dout2, 4'hC);
        req2 = 0;
        tick;
        check("u2_idle_dv", dv2, 0);
        check("u2_hold", dout2, 4'hC);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
